// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM state type and helpers for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_AUIPC = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_SLT   = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_MUL   = 4'b1100;
    localparam logic [3:0] ALU_MULHU = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // mul/mulhu/divu/remu share the 11xx op-code quadrant
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
// Result of the final step is offered combinationally on res_c while last_c is high.
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op_div,
    input  logic            op_hi,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_c,
    output logic            last_c
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opb;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              sel_hi;

    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     sh;
    logic [XLEN-1:0]   diff;
    logic              ge;

    assign hi = acc[2*XLEN-1:XLEN];
    assign lo = acc[XLEN-1:0];

    // hi:lo is product-high:multiplier for mul, remainder:quotient for div
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        sh   = {hi, lo[XLEN-1]};
        ge   = sh >= {1'b0, opb};
        diff = sh[XLEN-1:0] - opb;
        if (is_div) begin
            acc_nxt = {(ge ? diff : sh[XLEN-1:0]), lo[XLEN-2:0], ge};
        end else begin
            acc_nxt = {sum, lo[XLEN-1:1]};
        end
    end

    assign res_c  = sel_hi ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    assign last_c = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sel_hi <= 1'b0;
        end else if (start) begin
            acc    <= {{XLEN{1'b0}}, a};
            opb    <= b;
            cnt    <= CNT_W'(XLEN);
            is_div <= op_div;
            sel_hi <= op_hi;
        end else if (cnt != '0) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshake and registered result/zero.
// Define ALU_MULDIV_EN to include the iterative mul/mulhu/divu/remu engine.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SH_W = $clog2(XLEN);

    alu_state_t      state;
    alu_state_t      state_nxt;
    logic [XLEN-1:0] result_nxt;
    logic            zero_nxt;
    logic            valid_nxt;
    logic [XLEN-1:0] alu_res_c;
    logic            accept_c;

`ifdef ALU_MULDIV_EN
    logic            start_c;
    logic [XLEN-1:0] md_res_c;
    logic            md_last_c;

    alu_muldiv_seq #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .op_div (op[1]),
        .op_hi  (op[0]),
        .a      (a),
        .b      (b),
        .res_c  (md_res_c),
        .last_c (md_last_c)
    );
`endif

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept_c = in_valid && in_ready;

    // Single-cycle datapath; mul/div codes fall to zero when no engine is built
    always_comb begin
        alu_res_c = '0;
        case (op)
            ALU_ADD, ALU_AUIPC: alu_res_c = a + b;
            ALU_SUB:            alu_res_c = a - b;
            ALU_AND:            alu_res_c = a & b;
            ALU_OR:             alu_res_c = a | b;
            ALU_XOR:            alu_res_c = a ^ b;
            ALU_SLL:            alu_res_c = a << b[SH_W-1:0];
            ALU_SRL:            alu_res_c = a >> b[SH_W-1:0];
            ALU_LUI:            alu_res_c = b;
            ALU_SRA:            alu_res_c = $signed(a) >>> b[SH_W-1:0];
            ALU_SLT:            alu_res_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:           alu_res_c = {{(XLEN-1){1'b0}}, (a < b)};
            default:            alu_res_c = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        zero_nxt   = zero;
        valid_nxt  = out_valid;
`ifdef ALU_MULDIV_EN
        start_c    = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if ((state == DONE) && out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
                // A DONE transfer and a new acceptance may share one cycle
                if (accept_c) begin
`ifdef ALU_MULDIV_EN
                    if (is_muldiv(op)) begin
                        start_c   = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = BUSY;
                    end else
`endif
                    begin
                        result_nxt = alu_res_c;
                        zero_nxt   = (alu_res_c == '0);
                        valid_nxt  = 1'b1;
                        state_nxt  = DONE;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                if (md_last_c) begin
                    result_nxt = md_res_c;
                    zero_nxt   = (md_res_c == '0);
                    valid_nxt  = 1'b1;
                    state_nxt  = DONE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            result    <= result_nxt;
            zero      <= zero_nxt;
            out_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

    localparam int unsigned XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic [3:0]  s_op [8];
    logic [31:0] s_a  [8];
    logic [31:0] s_b  [8];

    always #5 clk = ~clk;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0]        p;
        logic signed [31:0] xs;
        int unsigned        s;
        p  = {32'b0, x} * {32'b0, y};
        xs = x;
        s  = int'(y[4:0]);
        case (o)
            4'd0, 4'd8: return x + y;
            4'd1:       return x - y;
            4'd2:       return x & y;
            4'd3:       return x | y;
            4'd4:       return x ^ y;
            4'd5:       return x << s;
            4'd6:       return x >> s;
            4'd7:       return y;
            4'd9:       return xs >>> s;
            4'd10:      return (xs < $signed(y)) ? 32'd1 : 32'd0;
            4'd11:      return (x < y) ? 32'd1 : 32'd0;
            4'd12:      return MD ? p[31:0] : 32'd0;
            4'd13:      return MD ? p[63:32] : 32'd0;
            4'd14:      return MD ? ((y == 0) ? 32'hFFFF_FFFF : x / y) : 32'd0;
            default:    return MD ? ((y == 0) ? x : x % y) : 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        return (MD && o >= 4'd12) ? XLEN + 1 : 1;
    endfunction

    // Issue one op from IDLE, scramble inputs after acceptance, wait for the result
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [31:0] exp;
        int          cyc;
        exp = ref_model(o, x, y);
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        if (latency(o) > 1) check({tag, "_busy"}, in_ready, 0);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(latency(o)));
        check({tag, "_res"}, result, exp);
        check({tag, "_zero"}, zero, (exp == 0));
    endtask

    // Back-to-back single-cycle ops with out_ready held high
    task automatic stream(input string tag, input int n);
        logic [31:0] exp;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_rdy"}, in_ready, 1);
            in_valid = 1'b1; op = s_op[i]; a = s_a[i]; b = s_b[i];
            exp = ref_model(s_op[i], s_a[i], s_b[i]);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_vld"}, out_valid, 1);
            check({tag, "_res"}, result, exp);
            check({tag, "_zero"}, zero, (exp == 0));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_res", result, 0);
        check("rst_zero", zero, 0);
        check("rst_rdy", in_ready, 1);
        rst_n = 1'b1;

        s_op[0] = 4'd0;  s_a[0] = 32'd5;          s_b[0] = 32'd7;
        s_op[1] = 4'd1;  s_a[1] = 32'd3;          s_b[1] = 32'd3;
        s_op[2] = 4'd9;  s_a[2] = 32'h8000_0000;  s_b[2] = 32'd4;
        s_op[3] = 4'd11; s_a[3] = 32'd1;          s_b[3] = 32'd2;
        stream("dir_str", 4);
        check("str_add_ref", ref_model(4'd0, 5, 7), 12);
        check("str_sra_ref", ref_model(4'd9, 32'h8000_0000, 4), 32'hF800_0000);

        for (int i = 0; i < 8; i++) begin
            s_op[i] = 4'($urandom_range(0, 11)); s_a[i] = $urandom; s_b[i] = $urandom;
        end
        stream("rnd_str", 8);

        run_op("mul",   4'd12, 32'hFFFF_FFFF, 32'd2);
        run_op("mulhu", 4'd13, 32'hFFFF_FFFF, 32'd2);
        run_op("divu",  4'd14, 32'd100, 32'd7);
        run_op("remu",  4'd15, 32'd100, 32'd7);
        run_op("divu0", 4'd14, 32'd5, 32'd0);
        run_op("remu0", 4'd15, 32'd5, 32'd0);
        run_op("sll31", 4'd5,  32'h0000_0003, 32'hFFFF_FFFF);
        run_op("slt_n", 4'd10, 32'hFFFF_FFFF, 32'd1);

        // Stall: result must hold and nothing new is accepted
        @(negedge clk);
        in_valid = 1'b1; op = 4'd4; a = 32'hF0; b = 32'hFF; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 4'd0; a = 32'd1; b = 32'd1;
        for (int k = 0; k < 10; k++) begin
            check("hold_res", result, 32'h0F);
            check("hold_vld", out_valid, 1);
            check("hold_rdy", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rel_vld", out_valid, 0);
        @(negedge clk);
        check("rel_vld2", out_valid, 0);

        // Reset ten cycles into a divide (or a stalled result when no engine)
        in_valid = 1'b1; op = 4'd14; a = 32'd100; b = 32'd7; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("pre_rst_rdy", in_ready, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_vld", out_valid, 0);
        check("mrst_res", result, 0);
        check("mrst_zero", zero, 0);
        check("mrst_rdy", in_ready, 1);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_vld", out_valid, 0);
        end
        run_op("add_after", 4'd0, 32'd1, 32'd1);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        for (int i = 0; i < 6; i++) begin
            run_op("rnd_div", 4'($urandom_range(14, 15)), $urandom, 32'($urandom_range(0, 300)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
